sprite_fetcher: RTL and testbench

Upstream address generator and downstream pixel unpacker for `memory_block`. It converts the raster position from the VGA timing generator into `memory_block` word addresses for a rectangular sprite window, drives the sprite selector, and splits each returned 48-bit word into two 24-bit pixels. It emits one aligned pixel per clock toward the VGA output stage.

---
 rtl/genius_pkg.sv | 27 ++
 rtl/pix_delay.sv | 31 +++
 rtl/sprite_fetcher.sv | 133 +++++++++++++
 tb/tb_sprite_fetcher.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// genius_pkg
// Shared definitions for the sprite path in front of memory_block:
//   - sel_e        : image selector encoding understood by memory_block
//   - PIX_W/WORD_W : one pixel is 24-bit RGB, one ROM word packs two pixels
//   - fetch_state_e: frame synchronisation state of sprite_fetcher
package genius_pkg;

   localparam int unsigned PIX_W  = 24;
   localparam int unsigned WORD_W = 48;

   typedef enum logic [2:0] {
      BACKGROUND    = 3'd0,
      POWER_BTN_ON  = 3'd1,
      RED_BTN_ON    = 3'd2,
      GREEN_BTN_ON  = 3'd3,
      BLUE_BTN_ON   = 3'd4,
      YELLOW_BTN_ON = 3'd5,
      WIN_SCREEN    = 3'd6,
      LOSE_SCREEN   = 3'd7
   } sel_e;

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      RUN        = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/pix_delay.sv
// pix_delay
// N-deep, W-wide shift register with asynchronous clear, used to keep
// side-band flags in step with the memory read pipeline.
//   clk_i  : clock
//   rst_ni : asynchronous active-low clear of every stage
//   d_i    : value entering the line
//   q_o    : value leaving the line N clocks later
module pix_delay #(
   parameter int unsigned W = 1,
   parameter int unsigned N = 3
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] stage_q [N];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[N-1];

endmodule

// File: rtl/sprite_fetcher.sv
// sprite_fetcher
// Turns the VGA raster position into memory_block word addresses for a
// rectangular sprite window and splits each returned 48-bit word into two
// 24-bit pixels, one pixel per clock, 3 clocks after the raster position.
//   IN_CLK, IN_RST_N   : clock, asynchronous active-low reset
//   IN_X, IN_Y, IN_DE  : raster position and display enable
//   IN_SEL             : requested image, latched at frame start
//   MEM_RGB            : word from memory_block (even pixel in [47:24])
//   OUT_ADDR           : word address to memory_block
//   OUT_SELECTOR       : image selector to memory_block
//   OUT_RGB/HIT/DE     : aligned pixel, sprite flag and display enable
module sprite_fetcher
   import genius_pkg::*;
#(
   parameter int unsigned       SPR_X0 = 0,
   parameter int unsigned       SPR_Y0 = 0,
   parameter int unsigned       SPR_W  = 24,
   parameter int unsigned       SPR_H  = 21,
   parameter logic [PIX_W-1:0]  BG_RGB = 24'h000000
) (
   input  logic                IN_CLK,
   input  logic                IN_RST_N,
   input  logic [9:0]          IN_X,
   input  logic [9:0]          IN_Y,
   input  logic                IN_DE,
   input  logic [2:0]          IN_SEL,
   input  logic [WORD_W-1:0]   MEM_RGB,
   output logic [15:0]         OUT_ADDR,
   output logic [2:0]          OUT_SELECTOR,
   output logic [PIX_W-1:0]    OUT_RGB,
   output logic                OUT_HIT,
   output logic                OUT_DE
);

   localparam logic [10:0] X_LO       = 11'(SPR_X0);
   localparam logic [10:0] X_HI       = 11'(SPR_X0 + SPR_W);
   localparam logic [10:0] Y_LO       = 11'(SPR_Y0);
   localparam logic [10:0] Y_HI       = 11'(SPR_Y0 + SPR_H);
   localparam logic [10:0] Y_LAST     = 11'(SPR_Y0 + SPR_H - 1);
   localparam logic [9:0]  X0_10      = 10'(SPR_X0);
   localparam logic [9:0]  X_LAST_OFF = 10'(SPR_W - 1);
   localparam logic [15:0] HALF_W     = 16'(SPR_W / 2);

   fetch_state_e state_q;
   logic [15:0] rowBase_q, rowBase_d;
   logic [15:0] colWord_q, colWord_d;
   logic [15:0] addr_q, addr_d;
   logic [2:0]  sel_q;
   logic [PIX_W-1:0] rgb_q;
   logic        hit_q, de_q;

   logic [10:0] xExt, yExt;
   logic [9:0]  xOff;
   logic        frameStart, inWin, active;
   logic [15:0] rowBaseEff, colWordEff, fetchAddr;
   logic [2:0]  lineOut;

   assign xExt       = {1'b0, IN_X};
   assign yExt       = {1'b0, IN_Y};
   assign xOff       = IN_X - X0_10;
   assign frameStart = IN_DE && (IN_X == 10'd0) && (IN_Y == 10'd0);
   assign inWin      = IN_DE && (xExt >= X_LO) && (xExt < X_HI)
                       && (yExt >= Y_LO) && (yExt < Y_HI);
   // The frame-start pixel itself may lie in the window, so it counts as
   // active even though the state register still says WAIT_FRAME.
   assign active     = inWin && ((state_q == RUN) || frameStart);

   // Counter next-state. A frame start forces both counters to zero before
   // anything else is applied; the last window row and the last window
   // column never advance, which keeps the address within the image.
   always_comb begin
      rowBaseEff = frameStart ? 16'd0 : rowBase_q;
      colWordEff = (xOff == 10'd0) ? 16'd0 : colWord_q;
      fetchAddr  = rowBaseEff + colWordEff;
      rowBase_d  = rowBaseEff;
      colWord_d  = frameStart ? 16'd0 : colWord_q;
      addr_d     = addr_q;
      if (active) begin
         colWord_d = colWordEff;
         if (!xOff[0]) begin
            addr_d = fetchAddr;
         end else if (xOff != X_LAST_OFF) begin
            colWord_d = colWordEff + 16'd1;
         end
         if ((xOff == X_LAST_OFF) && (yExt != Y_LAST)) begin
            rowBase_d = rowBaseEff + HALF_W;
         end
      end
   end

   // {de, hit, half} ride two stages while the address and ROM registers
   // do their work; the output register below is the third stage.
   pix_delay #(.W(3), .N(2)) uDelay (
      .clk_i  (IN_CLK),
      .rst_ni (IN_RST_N),
      .d_i    ({IN_DE, active, xOff[0]}),
      .q_o    (lineOut)
   );

   // Frame sync state, counters, selector latch and output stage.
   always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
      if (!IN_RST_N) begin
         state_q   <= WAIT_FRAME;
         rowBase_q <= 16'd0;
         colWord_q <= 16'd0;
         addr_q    <= 16'd0;
         sel_q     <= 3'b000;
         rgb_q     <= BG_RGB;
         hit_q     <= 1'b0;
         de_q      <= 1'b0;
      end else begin
         if (frameStart) begin
            state_q <= RUN;
            sel_q   <= IN_SEL;
         end
         rowBase_q <= rowBase_d;
         colWord_q <= colWord_d;
         addr_q    <= addr_d;
         de_q      <= lineOut[2];
         hit_q     <= lineOut[1];
         if (!lineOut[1])     rgb_q <= BG_RGB;
         else if (lineOut[0]) rgb_q <= MEM_RGB[PIX_W-1:0];
         else                 rgb_q <= MEM_RGB[WORD_W-1:PIX_W];
      end
   end

   assign OUT_ADDR     = addr_q;
   assign OUT_SELECTOR = sel_q;
   assign OUT_RGB      = rgb_q;
   assign OUT_HIT      = hit_q;
   assign OUT_DE       = de_q;

endmodule

// File: tb/tb_sprite_fetcher.sv
// tb_sprite_fetcher
// Drives a small raster (32 columns, 28 visible) into sprite_fetcher with
// the default 24x21 window at the origin and a behavioural registered ROM.
module tb_sprite_fetcher;

   localparam logic [23:0] BG = 24'h0F0F0F;

   typedef struct {
      logic        de;
      logic        hit;
      logic        odd;
      logic [23:0] rgb;
   } expT;

   logic        clk = 1'b0;
   logic        rstN;
   logic [9:0]  inX, inY;
   logic        inDe;
   logic [2:0]  inSel;
   logic [47:0] memRgb;
   logic [15:0] outAddr;
   logic [2:0]  outSel;
   logic [23:0] outRgb;
   logic        outHit, outDe;

   int          total = 0;
   int          bad = 0;
   expT         expQ[$];
   logic [15:0] expAddr;
   logic [2:0]  expSel;
   logic        started;
   logic        romMode;
   logic        sumOn;
   logic [23:0] hiHalf;
   logic [63:0] wordSum;
   logic [63:0] refSum;
   logic [15:0] maxAddr;

   sprite_fetcher #(
      .SPR_X0(0), .SPR_Y0(0), .SPR_W(24), .SPR_H(21), .BG_RGB(BG)
   ) dut (
      .IN_CLK       (clk),
      .IN_RST_N     (rstN),
      .IN_X         (inX),
      .IN_Y         (inY),
      .IN_DE        (inDe),
      .IN_SEL       (inSel),
      .MEM_RGB      (memRgb),
      .OUT_ADDR     (outAddr),
      .OUT_SELECTOR (outSel),
      .OUT_RGB      (outRgb),
      .OUT_HIT      (outHit),
      .OUT_DE       (outDe)
   );

   always #5 clk = ~clk;

   // ROM image: a fixed split pattern, or an address-dependent word.
   function automatic logic [47:0] romWord(input logic [15:0] a, input logic splitMode);
      if (splitMode) return {24'hAAAAAA, 24'h555555};
      return {a[7:0] ^ 8'h5A, 16'(a * 16'd37), 8'(a[7:0] + 8'd1), 16'hC000 | a};
   endfunction

   // Registered memory with one clock of latency.
   always @(posedge clk) memRgb <= romWord(outAddr, romMode);

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One raster position per clock; expected output follows 3 clocks later.
   task automatic applyStimulus(input int x, input int y, input logic de);
      expT         e;
      logic [15:0] a;
      logic [47:0] w;
      @(negedge clk);
      if (outAddr > maxAddr) maxAddr = outAddr;
      checkOutput("addr", 64'(outAddr), 64'(expAddr));
      checkOutput("sel", 64'(outSel), 64'(expSel));
      if (expQ.size() == 3) begin
         e = expQ.pop_front();
         checkOutput("hit", 64'(outHit), 64'(e.hit));
         checkOutput("de", 64'(outDe), 64'(e.de));
         checkOutput("rgb", 64'(outRgb), 64'(e.rgb));
         if (sumOn && e.hit) begin
            if (!e.odd) hiHalf = outRgb;
            else        wordSum += 64'({hiHalf, outRgb});
         end
      end
      inX  = 10'(x);
      inY  = 10'(y);
      inDe = de;
      if (de && x == 0 && y == 0) begin
         started = 1'b1;
         expSel  = inSel;
      end
      e.de  = de;
      e.hit = de && (x < 24) && (y < 21) && started;
      e.odd = x[0];
      e.rgb = BG;
      if (e.hit) begin
         a = 16'(y * 12 + x / 2);
         if (!x[0]) expAddr = a;
         w = romWord(a, romMode);
         e.rgb = x[0] ? w[23:0] : w[47:24];
      end
      expQ.push_back(e);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic resetPulse();
      expT idle;
      @(negedge clk);
      #2;
      rstN = 1'b0;
      inDe = 1'b0;
      inX  = 10'd0;
      inY  = 10'd0;
      #1;
      checkOutput("rst_addr", 64'(outAddr), 64'd0);
      checkOutput("rst_sel", 64'(outSel), 64'd0);
      checkOutput("rst_rgb", 64'(outRgb), 64'(BG));
      checkOutput("rst_hit", 64'(outHit), 64'd0);
      checkOutput("rst_de", 64'(outDe), 64'd0);
      @(negedge clk);
      rstN = 1'b1;
      expQ.delete();
      idle.de = 1'b0; idle.hit = 1'b0; idle.odd = 1'b0; idle.rgb = BG;
      repeat (3) expQ.push_back(idle);
      expAddr = 16'd0;
      expSel  = 3'd0;
      started = 1'b0;
   endtask

   task automatic runRow(input int y);
      for (int x = 0; x < 32; x++) applyStimulus(x, y, x < 28);
   endtask

   initial begin
      rstN = 1'b0; inX = '0; inY = '0; inDe = 1'b0; inSel = 3'd1;
      romMode = 1'b0; sumOn = 1'b0; wordSum = '0; hiHalf = '0; maxAddr = '0;
      expAddr = '0; expSel = '0; started = 1'b0;
      refSum = '0;
      for (int a = 0; a < 252; a++) refSum += 64'(romWord(16'(a), 1'b0));

      resetPulse();
      // Mid-frame positions before any frame start: background only.
      for (int x = 3; x < 9; x++) applyStimulus(x, 5, 1'b1);

      // Frame 1: full sweep, selector change at row 5, blanking pause in row 3.
      sumOn = 1'b1;
      for (int y = 0; y < 23; y++) begin
         if (y == 5) inSel = 3'd6;
         for (int x = 0; x < 32; x++) begin
            if (y == 3 && x == 10) repeat (10) applyStimulus(10, 3, 1'b0);
            applyStimulus(x, y, x < 28);
         end
      end
      repeat (3) applyStimulus(40, 30, 1'b0);
      sumOn = 1'b0;
      checkOutput("word_sum", wordSum, refSum);
      checkOutput("max_addr", 64'(maxAddr), 64'd251);

      // Frame 2: split pattern, selector now 6; reset lands inside row 1.
      romMode = 1'b1;
      runRow(0);
      for (int x = 0; x < 11; x++) applyStimulus(x, 1, 1'b1);
      resetPulse();
      for (int x = 11; x < 28; x++) applyStimulus(x, 1, 1'b1);

      // Frame 3 restarted mid-sprite by a second frame start.
      runRow(0);
      runRow(1);
      runRow(0);
      runRow(1);
      repeat (3) applyStimulus(40, 30, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
